// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing helpers, receiver state encoding and
// frame layout constants. Used by both uart_recv and uart_send.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_IDX  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // sys_clk cycles per bit; integer division truncates the fraction
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int calc_sample_pt(input int bps_cnt);
    return bps_cnt / 2;
  endfunction

endpackage

// File: rtl/uart_recv_if.sv
// RX pin plus the byte/status outputs presented to the CPU-side UART logic.
// master: the receiver; slave: the consumer that also drives the pin in test.
interface uart_recv_if;
  import uart_pkg::*;

  logic                 uart_rxd;
  logic [DATA_BITS-1:0] uart_data;
  logic                 uart_done;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    input  uart_rxd,
    output uart_data,
    output uart_done,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output uart_rxd,
    input  uart_data,
    input  uart_done,
    input  frame_err,
    input  rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for an asynchronous, idle-high input, plus a
// falling-edge detector on the synchronised signal.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_i,
  output logic rxd_s_o,
  output logic start_flag_o
);

  logic [2:0] sync_q;

  // Flops reset to the idle level so reset release never looks like an edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, exactly like the hardware it describes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign rxd_s_o      = sync_q[1];
  assign start_flag_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done / framing-error pulses.
// Optional macro UART_RECV_MAJORITY_EN: 2-of-3 majority vote around mid-bit.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 30_000_000,
  parameter int UART_BPS = 128000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  uart_recv_if.master rx_if
);

  localparam int BPS_CNT   = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int SAMPLE_PT = calc_sample_pt(BPS_CNT);

  localparam logic [15:0] CNT_MAX  = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_SAMP = 16'(SAMPLE_PT);
  localparam logic [3:0]  LAST_IDX = 4'(DATA_BITS);
  localparam logic [3:0]  STOP_NUM = 4'(STOP_IDX);

  logic rxd_s;
  logic start_flag;

  uart_rx_sync u_sync (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .async_i      (rx_if.uart_rxd),
    .rxd_s_o      (rxd_s),
    .start_flag_o (start_flag)
  );

  rx_state_e            state_q,   state_d;
  logic [15:0]          clk_cnt_q, clk_cnt_d;
  logic [3:0]           rx_cnt_q,  rx_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 done_q,    done_d;
  logic                 err_q,     err_d;

  logic rollover;
  logic strobe;
  logic bit_val;

  assign rollover = (clk_cnt_q == CNT_MAX);

`ifdef UART_RECV_MAJORITY_EN
  localparam logic [15:0] CNT_SAMP_LO = 16'(SAMPLE_PT - 1);
  localparam logic [15:0] CNT_SAMP_HI = 16'(SAMPLE_PT + 1);

  // early_q[0] holds the sample at SAMPLE_PT-1, early_q[1] the one at SAMPLE_PT;
  // the third vote is the live sample at SAMPLE_PT+1, where the decision is made.
  logic [1:0] early_q, early_d;

  always_comb begin
    early_d = early_q;
    if (clk_cnt_q == CNT_SAMP_LO) early_d[0] = rxd_s;
    if (clk_cnt_q == CNT_SAMP)    early_d[1] = rxd_s;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) early_q <= 2'b11;
    else            early_q <= early_d;
  end

  assign strobe  = (clk_cnt_q == CNT_SAMP_HI);
  assign bit_val = (early_q[0] & early_q[1]) | (early_q[0] & rxd_s) | (early_q[1] & rxd_s);
`else
  assign strobe  = (clk_cnt_q == CNT_SAMP);
  assign bit_val = rxd_s;
`endif

  // Bit timing restarts from zero on every frame because IDLE holds both counters clear.
  always_comb begin
    clk_cnt_d = 16'd0;
    rx_cnt_d  = 4'd0;
    if (state_q != IDLE) begin
      clk_cnt_d = rollover ? 16'd0 : clk_cnt_q + 16'd1;
      rx_cnt_d  = rollover ? rx_cnt_q + 4'd1 : rx_cnt_q;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_flag) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch, not a frame.
        if (strobe) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (strobe && rx_cnt_q != 4'd0) shift_d[3'(rx_cnt_q - 4'd1)] = bit_val;
        if (rollover && rx_cnt_q == LAST_IDX) state_d = STOP;
      end
      STOP: begin
        // Leaving at mid stop bit gives half a bit of slack for the next start edge.
        if (strobe && rx_cnt_q == STOP_NUM) begin
          state_d = IDLE;
          if (bit_val) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: shift_q is reset along with the rest; it is a plain 8-bit register,
  // not a memory array, so the reset costs nothing and keeps it X-free.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= 16'd0;
      rx_cnt_q  <= 4'd0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rx_if.uart_data = data_q;
  assign rx_if.uart_done = done_q;
  assign rx_if.frame_err = err_q;
  assign rx_if.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: behavioural 8N1 line driver, output
// monitor and a waveform-level decoding model for expected bytes and timing.
module tb_uart_recv;

  localparam int CLK_FREQ = 30_000_000;
  localparam int UART_BPS = 128000;
  localparam int BIT_CYC  = CLK_FREQ / UART_BPS;
  localparam int MID      = BIT_CYC / 2;
  localparam int FRAME    = 10 * BIT_CYC;
`ifdef UART_RECV_MAJORITY_EN
  localparam bit MAJ = 1'b1;
  localparam int LAT = 3 + 9 * BIT_CYC + MID + 1;
`else
  localparam bit MAJ = 1'b0;
  localparam int LAT = 3 + 9 * BIT_CYC + MID;
`endif

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_recv_if u_if ();

  uart_recv #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_if     (u_if)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
    logic       busy_prev;
    logic       busy_now;
  } evt_t;

  evt_t evt_q[$];
  int   both_hi   = 0;
  logic busy_last = 1'b0;

  always @(negedge sys_clk) begin
    if (u_if.uart_done === 1'b1 && u_if.frame_err === 1'b1) both_hi++;
    if (u_if.uart_done === 1'b1 || u_if.frame_err === 1'b1)
      evt_q.push_back('{is_err: u_if.frame_err, data: u_if.uart_data, cyc: cyc,
                        busy_prev: busy_last, busy_now: u_if.rx_busy});
    busy_last = u_if.rx_busy;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Line level n negedges after the start edge of a frame carrying b.
  function automatic logic wave(input logic [7:0] b, input logic stop_v, input int glitch_n, input int n);
    int   idx;
    logic v;
    idx = n / BIT_CYC;
    if (idx == 0)      v = 1'b0;
    else if (idx >= 9) v = stop_v;
    else               v = b[idx-1];
    return (n == glitch_n) ? ~v : v;
  endfunction

  // The receiver sees the line through a two-flop delay and samples mid-bit,
  // so data bit i is decided from line position 1 + (i+1)*BIT_CYC + MID.
  function automatic logic [7:0] model_byte(input logic [7:0] b, input int glitch_n);
    logic [7:0] r;
    int p, votes;
    for (int i = 0; i < 8; i++) begin
      p = 1 + (i + 1) * BIT_CYC + MID;
      if (MAJ) begin
        votes = 0;
        for (int k = -1; k <= 1; k++) votes += int'(wave(b, 1'b1, glitch_n, p + k));
        r[i] = (votes >= 2);
      end else begin
        r[i] = wave(b, 1'b1, glitch_n, p);
      end
    end
    return r;
  endfunction

  // fall_cyc is the value cyc takes on the first rising edge that sees the start bit.
  task automatic drive_frame(input logic [7:0] b, input logic stop_v, input int glitch_n,
                             input int abort_n, output int fall_cyc);
    fall_cyc = 0;
    for (int n = 0; n < FRAME; n++) begin
      @(negedge sys_clk);
      if (n == abort_n) return;
      u_if.uart_rxd = wave(b, stop_v, glitch_n, n);
      if (n == 0) fall_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n     = 1'b0;
    u_if.uart_rxd = 1'b1;
    idle(3);
    n_chk++; if (u_if.uart_data !== 8'h00) $display("FAIL reset_data: got %h want 00", u_if.uart_data); else n_pass++;
    n_chk++; if (u_if.uart_done !== 1'b0)  $display("FAIL reset_done: got %b want 0", u_if.uart_done); else n_pass++;
    n_chk++; if (u_if.frame_err !== 1'b0)  $display("FAIL reset_err: got %b want 0", u_if.frame_err); else n_pass++;
    n_chk++; if (u_if.rx_busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", u_if.rx_busy); else n_pass++;
    sys_rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_clean();
    int f0, lat;
    evt_q.delete();
    drive_frame(8'h55, 1'b1, -1, -1, f0);
    idle(50);
    n_chk++; if (evt_q.size() !== 1) $display("FAIL clean_count: got %0d want 1", evt_q.size()); else n_pass++;
    if (evt_q.size() > 0) begin
      lat = evt_q[0].cyc - f0;
      n_chk++; if (evt_q[0].is_err !== 1'b0) $display("FAIL clean_kind: got err=%b want 0", evt_q[0].is_err); else n_pass++;
      n_chk++; if (evt_q[0].data !== model_byte(8'h55, -1)) $display("FAIL clean_data: got %h want %h", evt_q[0].data, model_byte(8'h55, -1)); else n_pass++;
      n_chk++; if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL clean_latency: got %0d want %0d+-1", lat, LAT); else n_pass++;
      n_chk++; if (evt_q[0].busy_prev !== 1'b1 || evt_q[0].busy_now !== 1'b0)
        $display("FAIL clean_busy_fall: got prev=%b now=%b want 1/0", evt_q[0].busy_prev, evt_q[0].busy_now); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int f0, f1, gap;
    evt_q.delete();
    drive_frame(8'hA5, 1'b1, -1, -1, f0);
    drive_frame(8'h3C, 1'b1, -1, -1, f1);
    idle(50);
    n_chk++; if (evt_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", evt_q.size()); else n_pass++;
    if (evt_q.size() >= 2) begin
      gap = evt_q[1].cyc - evt_q[0].cyc;
      n_chk++; if (evt_q[0].data !== 8'hA5) $display("FAIL b2b_data0: got %h want a5", evt_q[0].data); else n_pass++;
      n_chk++; if (evt_q[1].data !== 8'h3C) $display("FAIL b2b_data1: got %h want 3c", evt_q[1].data); else n_pass++;
      n_chk++; if (gap < FRAME - 2 || gap > FRAME + 2) $display("FAIL b2b_spacing: got %0d want %0d+-2", gap, FRAME); else n_pass++;
    end
  endtask

  task automatic test_false_start();
    int f0;
    evt_q.delete();
    @(negedge sys_clk);
    u_if.uart_rxd = 1'b0;
    idle(50);
    u_if.uart_rxd = 1'b1;
    idle(50);
    n_chk++; if (u_if.rx_busy !== 1'b1) $display("FAIL false_busy_hi: got %b want 1", u_if.rx_busy); else n_pass++;
    idle(30);
    n_chk++; if (u_if.rx_busy !== 1'b0) $display("FAIL false_busy_lo: got %b want 0", u_if.rx_busy); else n_pass++;
    idle(200);
    n_chk++; if (evt_q.size() !== 0) $display("FAIL false_no_pulse: got %0d events want 0", evt_q.size()); else n_pass++;
    drive_frame(8'h0F, 1'b1, -1, -1, f0);
    idle(50);
    n_chk++; if (evt_q.size() !== 1 || evt_q[0].data !== 8'h0F || evt_q[0].is_err !== 1'b0)
      $display("FAIL false_then_0f: got n=%0d data=%h want n=1 data=0f", evt_q.size(), (evt_q.size() > 0) ? evt_q[0].data : 8'hxx); else n_pass++;
  endtask

  task automatic test_frame_err();
    int f0;
    logic busy_in_break;
    evt_q.delete();
    drive_frame(8'hC3, 1'b0, -1, -1, f0);
    busy_in_break = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (u_if.rx_busy === 1'b1) busy_in_break = 1'b1;
    end
    u_if.uart_rxd = 1'b1;
    idle(100);
    n_chk++; if (evt_q.size() !== 1) $display("FAIL ferr_count: got %0d want 1", evt_q.size()); else n_pass++;
    if (evt_q.size() > 0) begin
      n_chk++; if (evt_q[0].is_err !== 1'b1) $display("FAIL ferr_kind: got err=%b want 1", evt_q[0].is_err); else n_pass++;
    end
    n_chk++; if (u_if.uart_data !== 8'h0F) $display("FAIL ferr_data_held: got %h want 0f", u_if.uart_data); else n_pass++;
    n_chk++; if (busy_in_break !== 1'b0) $display("FAIL ferr_break_restart: got busy=%b want 0", busy_in_break); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int f0;
    evt_q.delete();
    drive_frame(8'hFF, 1'b1, -1, 5 * BIT_CYC + MID, f0);
    n_chk++; if (u_if.rx_busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", u_if.rx_busy); else n_pass++;
    sys_rst_n = 1'b0;
    #1;
    n_chk++; if (u_if.uart_data !== 8'h00 || u_if.uart_done !== 1'b0 || u_if.frame_err !== 1'b0 || u_if.rx_busy !== 1'b0)
      $display("FAIL rst_mid_outputs: got data=%h done=%b err=%b busy=%b want 00/0/0/0",
               u_if.uart_data, u_if.uart_done, u_if.frame_err, u_if.rx_busy); else n_pass++;
    u_if.uart_rxd = 1'b1;
    idle(4);
    sys_rst_n = 1'b1;
    idle(2 * FRAME);
    n_chk++; if (evt_q.size() !== 0) $display("FAIL rst_mid_no_pulse: got %0d events want 0", evt_q.size()); else n_pass++;
    drive_frame(8'h81, 1'b1, -1, -1, f0);
    idle(50);
    n_chk++; if (evt_q.size() !== 1 || evt_q[0].data !== 8'h81)
      $display("FAIL rst_mid_then_81: got n=%0d data=%h want n=1 data=81", evt_q.size(), (evt_q.size() > 0) ? evt_q[0].data : 8'hxx); else n_pass++;
  endtask

  task automatic test_glitch();
    int f0, g, bit_i;
    logic [7:0] b, exp_b;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        b = 8'h00; bit_i = 2;
      end else begin
        b = 8'($urandom); bit_i = int'($urandom_range(0, 7));
      end
      g     = 1 + (bit_i + 1) * BIT_CYC + MID;
      exp_b = model_byte(b, g);
      evt_q.delete();
      drive_frame(b, 1'b1, g, -1, f0);
      idle(50);
      n_chk++; if (evt_q.size() !== 1 || evt_q[0].data !== exp_b)
        $display("FAIL glitch_%0d: byte %h bit %0d got n=%0d data=%h want %h", it, b, bit_i,
                 evt_q.size(), (evt_q.size() > 0) ? evt_q[0].data : 8'hxx, exp_b); else n_pass++;
    end
  endtask

  task automatic test_random();
    int f0;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    evt_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(model_byte(b, -1));
      drive_frame(b, 1'b1, -1, -1, f0);
      idle(int'($urandom_range(0, 40)));
    end
    idle(50);
    n_chk++; if (evt_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", evt_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < evt_q.size(); i++) begin
      n_chk++; if (evt_q[i].data !== exp_q[i] || evt_q[i].is_err !== 1'b0)
        $display("FAIL rand_data_%0d: got %h err=%b want %h", i, evt_q[i].data, evt_q[i].is_err, exp_q[i]); else n_pass++;
    end
  endtask

  initial begin
    u_if.uart_rxd = 1'b1;
    test_reset();
    test_clean();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid();
    test_glitch();
    test_random();
    n_chk++; if (both_hi !== 0) $display("FAIL done_err_overlap: got %0d cycles want 0", both_hi); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- 8N1 UART receiver; the counterpart to the team's uart_send transmitter at the same CLK_FREQ and UART_BPS.
- Synchronises the asynchronous uart_rxd pin and detects the start bit on its falling edge.
- Samples each bit at mid-period and presents the assembled byte with a one-cycle done pulse.
- Sits between the board RX pin and the CPU's UART MMIO/FIFO logic.

Parameters:
- CLK_FREQ, 30_000_000, system clock frequency in Hz.
- UART_BPS, 128000, baud rate.
- BPS_CNT (localparam), CLK_FREQ/UART_BPS (integer division; 234 at the defaults), sys_clk cycles per bit.
- SAMPLE_PT (localparam), BPS_CNT/2 (117 at the defaults), in-bit sample offset.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- uart_rxd  in  1  UART RX pin, asynchronous to sys_clk; idle high.
- uart_data  out  8  last good received byte, LSB first on the wire; held until the next good byte.
- uart_done  out  1  one-cycle pulse; uart_data is valid on this same cycle.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- rx_busy  out  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (async, active-low):
  - all synchroniser flops = 1.
  - uart_data = 8'h00; uart_done = 0; frame_err = 0; rx_busy = 0.
  - state = IDLE; clk_cnt = 0; rx_cnt = 0.
- Synchroniser:
  - rxd_d0 <- uart_rxd; rxd_d1 <- rxd_d0; rxd_d2 <- rxd_d1.
  - start_flag = rxd_d2 & ~rxd_d1 (falling edge).
  - All sampling uses rxd_d1.
- Counters:
  - clk_cnt (16b): 0..BPS_CNT-1, wraps; cleared whenever state==IDLE.
  - rx_cnt (4b): increments when clk_cnt==BPS_CNT-1; 0 = start bit, 1..8 = data[0..7], 9 = stop bit.
  - Sample strobe = (clk_cnt==SAMPLE_PT).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on start_flag.
  - START, at strobe:
    - if rxd_d1==1 -> false start; go to IDLE with no pulse.
    - else -> DATA.
  - DATA, at strobe:
    - shift_reg[rx_cnt-1] <= rxd_d1.
    - after bit 7 is sampled, go to STOP on the next rx_cnt rollover.
  - STOP, at strobe:
    - rxd_d1==1: uart_data <= shift_reg; uart_done=1 for 1 cycle; go to IDLE.
    - rxd_d1==0: frame_err=1 for 1 cycle; uart_data unchanged; go to IDLE.
- Return to IDLE happens at stop-bit mid-point. This leaves half a bit of margin, so back-to-back frames from uart_send are accepted.
- Latency: uart_done rises 3 + 9*BPS_CNT + SAMPLE_PT (±1) cycles after the pin falling edge; 2226 cycles at the defaults.
- Line held low after a framing error (break): no new start is detected until the line returns high and then falls again.
- start_flag is ignored outside IDLE.
- uart_done and frame_err are never both high on the same cycle.
- Reset mid-frame: immediate abort; no pulse; the partial byte is discarded.

Optional Feature:
- Macro: UART_RECV_MAJORITY_EN.
- Defined:
  - each bit (start, data, stop) is the 2-of-3 majority of rxd_d1 taken at clk_cnt == SAMPLE_PT-1, SAMPLE_PT and SAMPLE_PT+1.
  - the decision is taken at SAMPLE_PT+1.
  - adds 1 cycle to the latency.
  - a single-cycle glitch at mid-bit is rejected.
- Undefined: single sample at SAMPLE_PT, as described above.

Decomposition:
- Package uart_pkg:
  - BPS_CNT/SAMPLE_PT calculation function.
  - rx state enum (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - frame constants DATA_BITS=8 and STOP_IDX=9.
  - shared with uart_send.
- Sub-module uart_rx_sync:
  - 3-flop synchroniser plus falling-edge detector.
  - outputs rxd_s and start_flag.
  - reusable for other async inputs.

Test Plan:
- Clean byte: uart_send (same parameters) transmits 8'h55 -> one uart_done pulse; uart_data=8'h55 at pulse; frame_err stays 0; rx_busy falls on the same cycle.
- Back-to-back: 8'hA5 then 8'h3C with no idle gap -> two uart_done pulses; data A5 then 3C; inter-pulse spacing 10*BPS_CNT ±2 cycles.
- False start: uart_rxd low for 50 cycles, then high -> no uart_done, no frame_err; rx_busy deasserts at SAMPLE_PT; a following valid 8'h0F is received correctly.
- Framing error: drive 8'hC3 with stop bit forced low -> frame_err single pulse, no uart_done; uart_data keeps its previous value.
- Reset mid-frame: assert sys_rst_n=0 at data bit 4 of 8'hFF -> outputs at reset values immediately; after release a fresh 8'h81 is received correctly.
- With UART_RECV_MAJORITY_EN: 1-cycle glitch inverting data bit 2 at SAMPLE_PT while sending 8'h00 -> uart_data=8'h00; without the macro -> 8'h04.
